// File: rtl/calc_button_encoder.sv
// Keypad front end: synchronizes and debounces raw button levels, then turns each
// clean single-button press into one active_button_t event on a valid/ready handshake.
package calc_pkg;

  // Field order matches active_button_t code order, so the MSB (on) maps to B_ON.
  typedef struct packed {
    logic on;
    logic off;
    logic clr;
    logic mem_rc;
    logic mem_add;
    logic mem_sub;
    logic op_add;
    logic op_sub;
    logic op_mul;
    logic op_div;
    logic op_eq;
    logic dot;
    logic num_0;
    logic num_1;
    logic num_2;
    logic num_3;
    logic num_4;
    logic num_5;
    logic num_6;
    logic num_7;
    logic num_8;
    logic num_9;
  } buttons_t;

  typedef enum logic [4:0] {
    B_NONE    = 5'd0,
    B_ON      = 5'd1,
    B_OFF     = 5'd2,
    B_CLR     = 5'd3,
    B_MEM_RC  = 5'd4,
    B_MEM_ADD = 5'd5,
    B_MEM_SUB = 5'd6,
    B_OP_ADD  = 5'd7,
    B_OP_SUB  = 5'd8,
    B_OP_MUL  = 5'd9,
    B_OP_DIV  = 5'd10,
    B_OP_EQ   = 5'd11,
    B_DOT     = 5'd12,
    B_NUM_0   = 5'd13,
    B_NUM_1   = 5'd14,
    B_NUM_2   = 5'd15,
    B_NUM_3   = 5'd16,
    B_NUM_4   = 5'd17,
    B_NUM_5   = 5'd18,
    B_NUM_6   = 5'd19,
    B_NUM_7   = 5'd20,
    B_NUM_8   = 5'd21,
    B_NUM_9   = 5'd22
  } active_button_t;

endpackage

module calc_button_encoder #(
  parameter int unsigned DebounceCycles = 1000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  calc_pkg::buttons_t        buttons_i,
  output calc_pkg::active_button_t  active_button_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      chord_o,
  output logic                      overflow_o
);
  import calc_pkg::*;

  localparam int unsigned NumButtons = $bits(buttons_t);
  localparam int unsigned CntW = (DebounceCycles < 1) ? 1 : $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [NumButtons-1:0] ZeroVec = {NumButtons{1'b0}};
  localparam logic [NumButtons-1:0] OneVec = NumButtons'(1);
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHeld = 1'b1;

  if (DebounceCycles == 0) begin : g_param_check
    $fatal(1, "calc_button_encoder: DebounceCycles must be at least 1");
  end

  function automatic active_button_t encode(input logic [NumButtons-1:0] vec);
    active_button_t code;
    code = B_NONE;
    for (int i = 0; i < int'(NumButtons); i++) begin
      if (vec[i]) begin
        code = active_button_t'(5'(int'(NumButtons) - i));
      end
    end
    return code;
  endfunction

  logic [NumButtons-1:0] s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  blk_q, blk_d;
  logic [0:0]            state_q, state_d;
  logic                  valid_q, valid_d, chord_q, chord_d, ovf_q, ovf_d;
  active_button_t        code_q, code_d;
  logic                  settled_s, one_hot_s, press_s, chord_s;

  // Synchronizer, debounce counter and accepted level; blk_q holds off presses
  // that were already down when reset released until a debounced all-zero is seen.
  always_comb begin
    s1_d      = buttons_i;
    s2_d      = s1_q;
    settled_s = (cnt_q == CntMax);
    if (s1_q != s2_q) begin
      cnt_d = {CntW{1'b0}};
    end else if (!settled_s) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end
    if (settled_s && !blk_q && (s2_q != stable_q)) begin
      stable_d = s2_q;
    end else begin
      stable_d = stable_q;
    end
    if (settled_s && (s2_q == ZeroVec)) begin
      blk_d = 1'b0;
    end else begin
      blk_d = blk_q;
    end
  end

  // Press FSM and output handshake.
  always_comb begin
    one_hot_s = (stable_q != ZeroVec) && ((stable_q & (stable_q - OneVec)) == ZeroVec);
    state_d   = state_q;
    press_s   = 1'b0;
    chord_s   = 1'b0;
    case (state_q)
      StIdle: begin
        if (stable_q != ZeroVec) begin
          state_d = StHeld;
          if (one_hot_s) begin
            press_s = 1'b1;
          end else begin
            chord_s = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StHeld: begin
        if (stable_q == ZeroVec) begin
          state_d = StIdle;
        end else begin
          state_d = StHeld;
        end
      end
      default: state_d = StIdle;
    endcase

    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    chord_d = chord_s;
    if (press_s) begin
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        code_d  = encode(stable_q);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= ZeroVec;
      s2_q     <= ZeroVec;
      stable_q <= ZeroVec;
      cnt_q    <= {CntW{1'b0}};
      blk_q    <= 1'b1;
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      code_q   <= B_NONE;
      chord_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      chord_q  <= chord_d;
      ovf_q    <= ovf_d;
    end
  end

  assign active_button_o = code_q;
  assign valid_o         = valid_q;
  assign chord_o         = chord_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_calc_button_encoder.sv
// Scoreboard bench for calc_button_encoder with DebounceCycles=4.
module tb_calc_button_encoder;
  import calc_pkg::*;

  localparam int Deb = 4;
  localparam int Lat = Deb + 3;

  logic           clk = 1'b0;
  logic           rst_i;
  buttons_t       buttons;
  active_button_t active_button_o;
  logic           valid_o, ready_i, chord_o, overflow_o;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int vhi_cnt = 0;
  int chord_cnt = 0;
  int ovf_cnt = 0;
  active_button_t sb[$];

  calc_button_encoder #(.DebounceCycles(Deb)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .buttons_i       (buttons),
    .active_button_o (active_button_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .chord_o         (chord_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Returns the number of steps until valid_o is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid_o && n < 60);
  endtask

  // Accepted events are popped and compared on the cycle the handshake completes.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o) vhi_cnt++;
      if (chord_o) chord_cnt++;
      if (overflow_o) ovf_cnt++;
      if (valid_o && ready_i) begin
        active_button_t exp;
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = B_NONE;
        check("sb_code", 32'(active_button_o), 32'(exp));
        acc_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_acc, base_vhi, base_chord, base_ovf;

    // Reset while num_7 is held
    rst_i   = 1'b1;
    ready_i = 1'b1;
    buttons = '0;
    buttons.num_7 = 1'b1;
    steps(3);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_chord", 32'(chord_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_code", 32'(active_button_o), 32'(B_NONE));
    rst_i = 1'b0;
    steps(20);
    check("held_thru_rst", 32'(vhi_cnt), 32'd0);
    buttons = '0;
    steps(12);
    buttons.num_7 = 1'b1;
    sb.push_back(B_NUM_7);
    wait_valid(n);
    check("lat_num7", 32'(n - 1), 32'(Lat));
    buttons = '0;
    steps(12);

    // Clean press of num_5
    base_acc = acc_cnt;
    buttons.num_5 = 1'b1;
    sb.push_back(B_NUM_5);
    wait_valid(n);
    check("lat_num5", 32'(n - 1), 32'(Lat));
    check("code_num5", 32'(active_button_o), 32'(B_NUM_5));
    step();
    check("num5_one_cycle", 32'(valid_o), 32'd0);
    steps(20);
    check("num5_single_event", 32'(acc_cnt - base_acc), 32'd1);
    buttons = '0;
    steps(12);

    // Bouncy op_add, ending high
    base_acc = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      buttons.op_add = ~buttons.op_add;
      steps(2);
    end
    buttons.op_add = 1'b1;
    sb.push_back(B_OP_ADD);
    wait_valid(n);
    check("lat_bounce", 32'(n - 1), 32'(Lat));
    steps(15);
    check("bounce_single_event", 32'(acc_cnt - base_acc), 32'd1);
    buttons = '0;
    steps(12);

    // Chord num_1|num_2, then num_3
    base_chord = chord_cnt;
    base_vhi   = vhi_cnt;
    buttons.num_1 = 1'b1;
    buttons.num_2 = 1'b1;
    steps(15);
    check("chord_pulse", 32'(chord_cnt - base_chord), 32'd1);
    check("chord_no_valid", 32'(vhi_cnt - base_vhi), 32'd0);
    buttons = '0;
    steps(12);
    buttons.num_3 = 1'b1;
    sb.push_back(B_NUM_3);
    wait_valid(n);
    check("lat_num3", 32'(n - 1), 32'(Lat));
    buttons = '0;
    steps(12);

    // Backpressure: dot pending, mem_rc dropped
    ready_i  = 1'b0;
    base_ovf = ovf_cnt;
    buttons.dot = 1'b1;
    sb.push_back(B_DOT);
    wait_valid(n);
    check("lat_dot", 32'(n - 1), 32'(Lat));
    buttons = '0;
    steps(12);
    buttons.mem_rc = 1'b1;
    steps(12);
    check("bp_ovf_pulse", 32'(ovf_cnt - base_ovf), 32'd1);
    check("bp_valid_held", 32'(valid_o), 32'd1);
    check("bp_code_kept", 32'(active_button_o), 32'(B_DOT));
    buttons = '0;
    steps(12);
    ready_i = 1'b1;
    step();
    check("bp_valid_fall", 32'(valid_o), 32'd0);

    // Accept on the same edge a new press loads
    ready_i  = 1'b0;
    base_ovf = ovf_cnt;
    buttons.op_mul = 1'b1;
    sb.push_back(B_OP_MUL);
    wait_valid(n);
    check("lat_mul", 32'(n - 1), 32'(Lat));
    buttons = '0;
    steps(12);
    buttons.op_div = 1'b1;
    sb.push_back(B_OP_DIV);
    steps(Lat);
    check("an_mul_still", 32'(active_button_o), 32'(B_OP_MUL));
    ready_i = 1'b1;
    step();
    check("an_valid_kept", 32'(valid_o), 32'd1);
    check("an_code_new", 32'(active_button_o), 32'(B_OP_DIV));
    check("an_no_ovf", 32'(overflow_o), 32'd0);
    step();
    check("an_valid_fall", 32'(valid_o), 32'd0);
    check("an_ovf_total", 32'(ovf_cnt - base_ovf), 32'd0);
    buttons = '0;
    steps(12);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
